// File: rtl/trigger_link_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_link_pkg
//  Description : Shared constants, FSM state type and CRC helper for the
//                trigger link framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package trigger_link_pkg;

  // Link control words
  localparam logic [31:0] IDLE_WORD = 32'h505050BC;
  localparam logic [31:0] FILL_WORD = 32'hF7F7F7F7;
  localparam logic [7:0]  HDR_COMMA = 8'hBC;
  localparam logic [15:0] TRL_MARK  = 16'hFEFE;

  // CRC-CCITT, no reflection, no final XOR
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } state_t;

  // Advance the CRC over one 32-bit word, MSB first.
  function automatic logic [15:0] crc16_step32(input logic [15:0] crc_in,
                                               input logic [31:0] data);
    logic [15:0] crc;
    logic        fb;
    crc = crc_in;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[15] ^ data[i];
      crc = {crc[14:0], 1'b0};
      if (fb) crc = crc ^ CRC_POLY;
    end
    return crc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_link_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_link_framer_if
//  Description : Trigger-word input stream, BX-zero marker and link output
//                of the framer. 'master' is the upstream/serializer side,
//                'slave' is the framer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trigger_link_framer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              bc0;
  logic [DATA_W-1:0] m_data;
  logic              m_k;
  logic              m_sof;

  modport master (
    output s_data, s_valid, bc0,
    input  s_ready, m_data, m_k, m_sof
  );

  modport slave (
    input  s_data, s_valid, bc0,
    output s_ready, m_data, m_k, m_sof
  );
endinterface
`default_nettype wire

// File: rtl/trigger_link_framer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_link_fifo
//  Description : Synchronous show-ahead FIFO. rd_data always presents the
//                oldest entry; count/full/empty come from the registered
//                occupancy, so a same-cycle pop frees a slot one cycle later.
//                FIFO_DEPTH must be a power of two, at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_link_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset, the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/trigger_link_framer.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_link_framer
//  Description : Buffers formatted trigger words and packs them into fixed
//                length link frames: header (BX, sequence, payload count),
//                WORDS_PER_FRAME payload/filler slots and, when the macro
//                TRIG_FRAMER_CRC_EN is defined, a CRC-16 trailer. Idle words
//                are sent whenever no frame is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_link_framer
  import trigger_link_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_FRAME = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int BX_MAX          = 3563
) (
  input  logic                 clock,
  input  logic                 reset,
  trigger_link_framer_if.slave link,
  output logic [31:0]          frame_cnt,
  output logic [15:0]          stall_cnt
);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  WPF       = 4'(WORDS_PER_FRAME);
  localparam logic [3:0]  LAST_SLOT = 4'(WORDS_PER_FRAME - 1);
  localparam logic [11:0] BX_LAST   = 12'(BX_MAX);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        slot;
  logic [3:0]        slot_nxt;
  logic [3:0]        n_lat;
  logic [3:0]        n_nxt;
  logic [3:0]        n_avail;
  logic [3:0]        seq;
  logic [11:0]       bx;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] data_nxt;
  logic [DATA_W-1:0] hdr_word;
  logic              out_k;
  logic              k_nxt;
  logic              out_sof;
  logic              sof_nxt;
  logic              hdr;
  logic              pop;
  logic              push;

  logic [DATA_W-1:0] fifo_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef TRIG_FRAMER_CRC_EN
  logic [15:0]       crc;
  logic [15:0]       crc_nxt;
`endif

  assign push         = link.s_valid & ~fifo_full;
  assign link.s_ready = ~fifo_full;
  assign link.m_data  = out_data;
  assign link.m_k     = out_k;
  assign link.m_sof   = out_sof;

  trigger_link_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (link.s_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Payload count of the next frame: whatever is queued, capped at one frame.
  assign n_avail  = (fifo_count >= CNT_W'(WORDS_PER_FRAME)) ? WPF : 4'(fifo_count);
  assign hdr_word = {HDR_COMMA, bx, seq, 4'h0, n_avail};

  // Next state and next registered output word.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    n_nxt     = n_lat;
    pop       = 1'b0;
    hdr       = 1'b0;
    data_nxt  = IDLE_WORD;
    k_nxt     = 1'b1;
    sof_nxt   = 1'b0;
`ifdef TRIG_FRAMER_CRC_EN
    crc_nxt   = crc;
`endif
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          hdr       = 1'b1;
          state_nxt = PAYLOAD;
          slot_nxt  = 4'd0;
          n_nxt     = n_avail;
          data_nxt  = hdr_word;
          sof_nxt   = 1'b1;
`ifdef TRIG_FRAMER_CRC_EN
          crc_nxt   = crc16_step32(CRC_INIT, hdr_word);
`endif
        end
      end
      PAYLOAD: begin
        // Only the n words present at the header go into this frame.
        if (slot < n_lat) begin
          pop      = 1'b1;
          data_nxt = fifo_data;
          k_nxt    = 1'b0;
        end else begin
          data_nxt = FILL_WORD;
        end
`ifdef TRIG_FRAMER_CRC_EN
        crc_nxt = crc16_step32(crc, data_nxt);
`endif
        if (slot == LAST_SLOT) begin
`ifdef TRIG_FRAMER_CRC_EN
          state_nxt = TRAILER;
`else
          // IDLE re-checks the FIFO on the next edge, so a pending word
          // starts the next header with no idle word in between.
          state_nxt = IDLE;
`endif
        end else begin
          slot_nxt = slot + 4'd1;
        end
      end
`ifdef TRIG_FRAMER_CRC_EN
      TRAILER: begin
        data_nxt  = {TRL_MARK, crc};
        k_nxt     = 1'b0;
        state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, output word registers, sequence and frame counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      slot      <= 4'd0;
      n_lat     <= 4'd0;
      seq       <= 4'd0;
      out_data  <= IDLE_WORD;
      out_k     <= 1'b1;
      out_sof   <= 1'b0;
      frame_cnt <= 32'd0;
    end else begin
      state    <= state_nxt;
      slot     <= slot_nxt;
      n_lat    <= n_nxt;
      out_data <= data_nxt;
      out_k    <= k_nxt;
      out_sof  <= sof_nxt;
      if (hdr) begin
        seq       <= seq + 4'd1;
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

`ifdef TRIG_FRAMER_CRC_EN
  // Running CRC over the frame in flight.
  always_ff @(posedge clock) begin
    if (reset) crc <= CRC_INIT;
    else       crc <= crc_nxt;
  end
`endif

  // Bunch-crossing counter; bc0 wins over the natural wrap.
  always_ff @(posedge clock) begin
    if (reset)                bx <= 12'd0;
    else if (link.bc0)        bx <= 12'd0;
    else if (bx == BX_LAST)   bx <= 12'd0;
    else                      bx <= bx + 12'd1;
  end

  // Back-pressure cycle counter, saturating.
  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt <= 16'd0;
    else if (link.s_valid && !link.s_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_trigger_link_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trigger_link_framer
//  Description : Self-checking bench for trigger_link_framer (default build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_link_framer;
  import trigger_link_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] frame_cnt;
  logic [15:0] stall_cnt;

  always #5 clock = ~clock;

  trigger_link_framer_if #(.DATA_W(32)) link ();

  trigger_link_framer #(
    .DATA_W          (32),
    .WORDS_PER_FRAME (4),
    .FIFO_DEPTH      (16),
    .BX_MAX          (3563)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .link      (link),
    .frame_cnt (frame_cnt),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic        bc0;
    logic [31:0] e_data;
    logic        e_k;
    logic        e_sof;
    logic        e_ready;
    logic [31:0] e_fcnt;
  } vec_t;

  vec_t vecs[$];
  int   tests    = 0;
  int   failures = 0;

  // continuous-stream scoreboard state
  logic [31:0] exp_pay;
  int          received;
  int          pay_err;
  int          seq_err;
  logic        seq_wrap;
  logic        have_seq;
  logic [3:0]  prev_seq;
  logic        saw_not_ready;

  task automatic add(input logic rst, input logic valid, input logic [31:0] data,
                     input logic bc0, input logic [31:0] e_data, input logic e_k,
                     input logic e_sof, input logic [31:0] e_fcnt);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.bc0 = bc0;
    v.e_data = e_data; v.e_k = e_k; v.e_sof = e_sof; v.e_ready = 1'b1; v.e_fcnt = e_fcnt;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; link.s_valid = 1'b0; link.s_data = '0; link.bc0 = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic observe();
    if (!link.s_ready) saw_not_ready = 1'b1;
    if (link.m_sof) begin
      if (have_seq && link.m_data[11:8] != prev_seq + 4'd1) seq_err++;
      if (have_seq && prev_seq == 4'd15 && link.m_data[11:8] == 4'd0) seq_wrap = 1'b1;
      prev_seq = link.m_data[11:8];
      have_seq = 1'b1;
    end else if (!link.m_k) begin
      if (link.m_data != exp_pay) pay_err++;
      exp_pay = exp_pay + 32'd1;
      received++;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] next_data;
    int          accepted;
    int          stall_model;

    // ---------------- vector table ----------------
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, IDLE_WORD, 1, 0, 0);
    add(0, 0, 32'h0,        1, IDLE_WORD,    1, 0, 0);   // v3 bc0
    add(0, 1, 32'hDEADBEEF, 0, IDLE_WORD,    1, 0, 0);   // v4 push
    add(0, 0, 32'h0,        0, 32'hBC001001, 1, 1, 1);   // v5 header bx=1 seq0 n1
    add(0, 0, 32'h0,        0, 32'hDEADBEEF, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, FILL_WORD, 1, 0, 1);
    add(0, 0, 32'h0,        0, IDLE_WORD,    1, 0, 1);   // v10
    add(0, 1, 32'h000000AA, 0, IDLE_WORD,    1, 0, 1);   // v11 priming word
    add(0, 1, 32'h1,        0, 32'hBC008101, 1, 1, 2);   // v12 header n1
    add(0, 1, 32'h2,        0, 32'h000000AA, 0, 0, 2);
    add(0, 1, 32'h3,        0, FILL_WORD,    1, 0, 2);
    add(0, 1, 32'h4,        0, FILL_WORD,    1, 0, 2);
    add(0, 1, 32'h5,        0, FILL_WORD,    1, 0, 2);
    add(0, 1, 32'h6,        0, 32'hBC00D204, 1, 1, 3);   // v17 back-to-back, n4
    for (int i = 1; i <= 4; i++) add(0, 0, 0, 0, 32'(i), 0, 0, 3);
    add(0, 0, 32'h0,        1, 32'hBC012302, 1, 1, 4);   // v22 bc0 on header edge
    add(0, 0, 32'h0,        0, 32'h5,        0, 0, 4);
    add(0, 0, 32'h0,        0, 32'h6,        0, 0, 4);
    add(0, 0, 32'h0,        0, FILL_WORD,    1, 0, 4);
    add(0, 0, 32'h0,        0, FILL_WORD,    1, 0, 4);
    add(0, 0, 32'h0,        0, IDLE_WORD,    1, 0, 4);   // v27
    add(0, 1, 32'h11,       0, IDLE_WORD,    1, 0, 4);
    add(0, 0, 32'h0,        0, 32'hBC006401, 1, 1, 5);   // v29 bx relative to bc0
    add(0, 0, 32'h0,        0, 32'h11,       0, 0, 5);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, FILL_WORD, 1, 0, 5);
    add(0, 0, 32'h0,        0, IDLE_WORD,    1, 0, 5);   // v34
    add(0, 1, 32'h21,       0, IDLE_WORD,    1, 0, 5);
    add(0, 1, 32'h22,       0, 32'hBC00D501, 1, 1, 6);   // v36
    add(0, 0, 32'h0,        0, 32'h21,       0, 0, 6);   // v37 slot 0
    add(1, 0, 32'h0,        0, IDLE_WORD,    1, 0, 0);   // v38 reset in slot 1
    add(0, 1, 32'h33,       0, IDLE_WORD,    1, 0, 0);   // FIFO was flushed
    add(0, 0, 32'h0,        0, 32'hBC001001, 1, 1, 1);   // seq 0, n1
    add(0, 0, 32'h0,        0, 32'h33,       0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, FILL_WORD, 1, 0, 1);
    add(0, 0, 32'h0,        0, IDLE_WORD,    1, 0, 1);

    foreach (vecs[i]) begin
      reset        = vecs[i].rst;
      link.s_valid = vecs[i].valid;
      link.s_data  = vecs[i].data;
      link.bc0     = vecs[i].bc0;
      step();
      tests++;
      if (link.m_data !== vecs[i].e_data || link.m_k !== vecs[i].e_k ||
          link.m_sof !== vecs[i].e_sof || link.s_ready !== vecs[i].e_ready ||
          frame_cnt !== vecs[i].e_fcnt) begin
        failures++;
        $display("FAIL vec%0d: got data=%h k=%b sof=%b rdy=%b fcnt=%0d, expected data=%h k=%b sof=%b rdy=%b fcnt=%0d",
                 i, link.m_data, link.m_k, link.m_sof, link.s_ready, frame_cnt,
                 vecs[i].e_data, vecs[i].e_k, vecs[i].e_sof, vecs[i].e_ready, vecs[i].e_fcnt);
      end
    end

    // ---------------- continuous input, 100 cycles ----------------
    do_reset();
    next_data = 32'h1000; exp_pay = 32'h1000;
    accepted = 0; received = 0; stall_model = 0; pay_err = 0; seq_err = 0;
    seq_wrap = 1'b0; have_seq = 1'b0; prev_seq = 4'd0; saw_not_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      link.s_valid = 1'b1;
      link.s_data  = next_data;
      if (!link.s_ready) stall_model++;
      else begin
        next_data = next_data + 32'd1;
        accepted++;
      end
      step();
      observe();
    end
    link.s_valid = 1'b0;
    for (int c = 0; c < 300 && received < accepted; c++) begin
      step();
      observe();
    end
    check("cont_ready_drop",  32'(saw_not_ready), 32'd1);
    check("cont_stall_cnt",   32'(stall_cnt),     32'(stall_model));
    check("cont_stall_nz",    32'(stall_cnt != 16'd0), 32'd1);
    check("cont_payload_err", 32'(pay_err),       32'd0);
    check("cont_count",       32'(received),      32'(accepted));
    check("cont_seq_step",    32'(seq_err),       32'd0);
    check("cont_seq_wrap",    32'(seq_wrap),      32'd1);

    // ---------------- reset clears counters ----------------
    do_reset();
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_frame_cnt", frame_cnt,      32'd0);
    check("rst_idle_word", link.m_data,    IDLE_WORD);

    // ---------------- BX wrap ----------------
    link.bc0 = 1'b1; step(); link.bc0 = 1'b0;
    repeat (3562) step();
    link.s_valid = 1'b1; link.s_data = 32'h5A5A0001; step();
    link.s_valid = 1'b0; step();
    check("bx_max_header", link.m_data, 32'hBCDEB001);
    check("bx_max_sof",    32'(link.m_sof), 32'd1);
    step();
    check("bx_max_payload", link.m_data, 32'h5A5A0001);
    repeat (3) step();
    link.s_valid = 1'b1; link.s_data = 32'h5A5A0002; step();
    link.s_valid = 1'b0; step();
    check("bx_wrap_header", link.m_data, 32'hBC005101);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
